// File: rtl/cam_if.sv
// Request/response bus of the 16-entry CAM controller, plus its occupancy status.
interface cam_if #(
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_key;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic [3:0]        resp_idx;
  logic              resp_err;
  logic [4:0]        count;
  logic              full;
  logic              empty;

  modport master (
    output req_valid, req_op, req_key, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_idx, resp_err, count, full, empty
  );

  modport slave (
    input  req_valid, req_op, req_key, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_idx, resp_err, count, full, empty
  );
endinterface

// File: rtl/cam_ctrl.sv
// 16-entry content-addressable table with a sequential one-entry-per-cycle scan
// supporting LOOKUP, INSERT, DELETE and FLUSH through a valid/ready handshake.
module cam_ctrl #(
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  cam_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] key_q;
  logic [3:0]        scan_idx_q;
  logic              free_found_q;
  logic [3:0]        free_idx_q;
  logic [3:0]        match_idx_q;
  logic [DATA_W-1:0] keys_q [16];
  logic [15:0]       valid_q;
  logic [4:0]        count_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_hit_q;
  logic [3:0]        resp_idx_q;
  logic              resp_err_q;

  logic              scan_hit;
  logic              scan_free;

  // Compare the single entry addressed by the scan index against the latched key.
  always_comb begin
    scan_hit  = 1'b0;
    scan_free = 1'b0;
    if (valid_q[scan_idx_q]) begin
      scan_hit = (keys_q[scan_idx_q] == key_q);
    end else begin
      scan_free = 1'b1;
    end
  end

  // Controller FSM, table storage and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LOOKUP;
      key_q        <= '0;
      scan_idx_q   <= 4'd0;
      free_found_q <= 1'b0;
      free_idx_q   <= 4'd0;
      match_idx_q  <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        keys_q[i] <= '0;
      end
      valid_q      <= 16'd0;
      count_q      <= 5'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= 4'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            op_q         <= bus.req_op;
            key_q        <= bus.req_key;
            scan_idx_q   <= 4'd0;
            free_found_q <= 1'b0;
            free_idx_q   <= 4'd0;
            match_idx_q  <= 4'd0;
            req_ready_q  <= 1'b0;
            state_q      <= (bus.req_op == OP_FLUSH) ? ST_WRITE : ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (scan_hit) begin
            match_idx_q <= scan_idx_q;
            if (op_q == OP_DELETE) begin
              state_q <= ST_WRITE;
            end else begin
              resp_valid_q <= 1'b1;
              resp_hit_q   <= 1'b1;
              resp_idx_q   <= scan_idx_q;
              resp_err_q   <= 1'b0;
              state_q      <= ST_RESP;
            end
          end else if (scan_idx_q == 4'd15) begin
            // Entry 15 is free-checked here since the tracker only covers 0..14.
            if (op_q == OP_INSERT && (free_found_q || scan_free)) begin
              if (!free_found_q) begin
                free_idx_q <= 4'd15;
              end
              state_q <= ST_WRITE;
            end else begin
              resp_valid_q <= 1'b1;
              resp_hit_q   <= 1'b0;
              resp_idx_q   <= 4'd0;
              resp_err_q   <= (op_q == OP_INSERT);
              state_q      <= ST_RESP;
            end
          end else begin
            if (scan_free && !free_found_q) begin
              free_found_q <= 1'b1;
              free_idx_q   <= scan_idx_q;
            end
            scan_idx_q <= scan_idx_q + 4'd1;
          end
        end

        ST_WRITE: begin
          case (op_q)
            OP_INSERT: begin
              keys_q[free_idx_q]  <= key_q;
              valid_q[free_idx_q] <= 1'b1;
              if (count_q != 5'd16) begin
                count_q <= count_q + 5'd1;
              end
              resp_hit_q <= 1'b0;
              resp_idx_q <= free_idx_q;
            end
            OP_DELETE: begin
              valid_q[match_idx_q] <= 1'b0;
              if (count_q != 5'd0) begin
                count_q <= count_q - 5'd1;
              end
              resp_hit_q <= 1'b1;
              resp_idx_q <= match_idx_q;
            end
            OP_FLUSH: begin
              valid_q    <= 16'd0;
              count_q    <= 5'd0;
              resp_hit_q <= 1'b0;
              resp_idx_q <= 4'd0;
            end
            default: begin
              resp_hit_q <= 1'b0;
              resp_idx_q <= 4'd0;
            end
          endcase
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end

        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_idx   = resp_idx_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.count      = count_q;
  assign bus.full       = (count_q == 5'd16);
  assign bus.empty      = (count_q == 5'd0);
endmodule

// File: tb/tb_cam_ctrl.sv
// Directed self-checking bench for cam_ctrl: latency, hit/idx/err and count
// behaviour of each operation, response back-pressure and mid-scan reset.
module tb_cam_ctrl;
  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cam_if #(.DATA_W(8)) bus ();

  cam_ctrl #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency from the acceptance cycle, optionally
  // hold the response for 'hold' cycles, then take it. Entered and left at #1 after an edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] key,
                        input logic [7:0] key_after, input int hold,
                        output logic [31:0] lat, output logic [31:0] hit,
                        output logic [31:0] idx, output logic [31:0] err);
    int w;
    int cyc;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_key   = key_after;
    cyc = 1;
    while (!bus.resp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    lat = 32'(cyc);
    hit = 32'(bus.resp_hit);
    idx = 32'(bus.resp_idx);
    err = 32'(bus.resp_err);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, "_hold_hit"},   32'(bus.resp_hit), hit);
      chk({tag, "_hold_idx"},   32'(bus.resp_idx), idx);
      chk({tag, "_hold_err"},   32'(bus.resp_err), err);
      chk({tag, "_hold_rdy"},   32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic expect_op(input string tag, input logic [1:0] op, input logic [7:0] key,
                           input int hold, input int e_lat, input int e_hit,
                           input int e_idx, input int e_err, input int e_cnt);
    logic [31:0] lat, hit, idx, err;
    run_op(tag, op, key, ~key, hold, lat, hit, idx, err);
    chk({tag, "_lat"},   lat, 32'(e_lat));
    chk({tag, "_hit"},   hit, 32'(e_hit));
    chk({tag, "_idx"},   idx, 32'(e_idx));
    chk({tag, "_err"},   err, 32'(e_err));
    chk({tag, "_count"}, 32'(bus.count), 32'(e_cnt));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_LOOKUP;
    bus.req_key    = 8'h00;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ready", 32'(bus.req_ready),  32'd1);
    chk("rst_empty", 32'(bus.empty),      32'd1);
    chk("rst_full",  32'(bus.full),       32'd0);
    chk("rst_count", 32'(bus.count),      32'd0);
    chk("rst_rvld",  32'(bus.resp_valid), 32'd0);
    chk("rst_hit",   32'(bus.resp_hit),   32'd0);
    chk("rst_idx",   32'(bus.resp_idx),   32'd0);
    chk("rst_err",   32'(bus.resp_err),   32'd0);

    //                tag          op         key    hold lat hit idx err cnt
    expect_op("lkp_5a",   OP_LOOKUP, 8'h5A, 0, 17, 0, 0, 0, 0);
    expect_op("ins_11",   OP_INSERT, 8'h11, 0, 18, 0, 0, 0, 1);
    expect_op("ins_22",   OP_INSERT, 8'h22, 0, 18, 0, 1, 0, 2);
    expect_op("ins_33",   OP_INSERT, 8'h33, 0, 18, 0, 2, 0, 3);
    expect_op("lkp_22",   OP_LOOKUP, 8'h22, 0,  3, 1, 1, 0, 3);
    expect_op("dup_22",   OP_INSERT, 8'h22, 0,  3, 1, 1, 0, 3);
    expect_op("del_11",   OP_DELETE, 8'h11, 0,  3, 1, 0, 0, 2);
    expect_op("ins_44",   OP_INSERT, 8'h44, 0, 18, 0, 0, 0, 3);
    expect_op("lkp_33",   OP_LOOKUP, 8'h33, 0,  4, 1, 2, 0, 3);
    expect_op("lkp_11",   OP_LOOKUP, 8'h11, 0, 17, 0, 0, 0, 3);
    expect_op("del_99",   OP_DELETE, 8'h99, 0, 17, 0, 0, 0, 3);
    expect_op("del_33",   OP_DELETE, 8'h33, 0,  5, 1, 2, 0, 2);
    expect_op("flush_a",  OP_FLUSH,  8'h00, 0,  2, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      expect_op($sformatf("fill_%0d", i), OP_INSERT, 8'(i), 0, 18, 0, i, 0, i + 1);
    end
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_empty", 32'(bus.empty), 32'd0);

    expect_op("lkp_0f",   OP_LOOKUP, 8'h0F, 0, 17, 1, 15, 0, 16);
    expect_op("ins_full", OP_INSERT, 8'h80, 0, 17, 0, 0, 1, 16);
    expect_op("ins_dupf", OP_INSERT, 8'h07, 0,  9, 1, 7, 0, 16);
    expect_op("flush_b",  OP_FLUSH,  8'h00, 0,  2, 0, 0, 0, 0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_full",  32'(bus.full),  32'd0);
    expect_op("lkp_gone", OP_LOOKUP, 8'h05, 0, 17, 0, 0, 0, 0);

    // Key bus changes after acceptance (expect_op drives ~key) must not matter.
    expect_op("ins_77",   OP_INSERT, 8'h77, 0, 18, 0, 0, 0, 1);
    expect_op("lkp_88",   OP_LOOKUP, 8'h88, 0, 17, 0, 0, 0, 1);
    expect_op("hold_77",  OP_LOOKUP, 8'h77, 5,  2, 1, 0, 0, 1);

    // Reset in the middle of an INSERT scan.
    chk("pre_rst_rdy", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_INSERT;
    bus.req_key   = 8'h66;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midscan_rdy", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_count", 32'(bus.count),      32'd0);
    chk("abort_rvld",  32'(bus.resp_valid), 32'd0);
    chk("abort_ready", 32'(bus.req_ready),  32'd1);
    chk("abort_empty", 32'(bus.empty),      32'd1);
    repeat (20) begin
      @(posedge clk); #1;
      chk("abort_quiet", 32'(bus.resp_valid), 32'd0);
    end
    expect_op("lkp_66",   OP_LOOKUP, 8'h66, 0, 17, 0, 0, 0, 0);
    expect_op("lkp_77r",  OP_LOOKUP, 8'h77, 0, 17, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
